rd_frame_buf: RTL and testbench



---
 rtl/rd_frame_buf.sv | 56 +++++
 tb/tb_rd_frame_buf.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/rd_frame_buf.sv
// rd_frame_buf: single-clock simple dual-port frame buffer.
// The write port takes full-width bursts from the DDR read engine. The read
// port returns one narrow lane per cycle to the pixel path, with one cycle of
// latency. A read and a write to the same word in the same cycle are
// read-first: the read returns the old contents.
module rd_frame_buf #(
  parameter int WR_ADDR_WIDTH = 9,
  parameter int WR_DATA_WIDTH = 256,
  parameter int RD_ADDR_WIDTH = 12,
  parameter int RD_DATA_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WR_ADDR_WIDTH-1:0] wr_addr,
  input  logic [WR_DATA_WIDTH-1:0] wr_data,
  input  logic [RD_ADDR_WIDTH-1:0] rd_addr,
  output logic [RD_DATA_WIDTH-1:0] rd_data
);

  // Lane-select width. The write word must be exactly LANES read lanes wide.
  localparam int LANE_BITS = RD_ADDR_WIDTH - WR_ADDR_WIDTH;
  localparam int LANES     = 1 << LANE_BITS;
  localparam int DEPTH     = 1 << WR_ADDR_WIDTH;

  // Each word is stored as a packed array of lanes. Lane 0 occupies the
  // least-significant bits, so a flat write word maps onto it directly.
  logic [LANES-1:0][RD_DATA_WIDTH-1:0] mem [DEPTH];

  // Split the read address into word index (upper bits) and lane (lower bits).
  logic [WR_ADDR_WIDTH-1:0] rd_word;
  logic [LANE_BITS-1:0]     rd_lane;

  assign rd_word = rd_addr[RD_ADDR_WIDTH-1:LANE_BITS];
  assign rd_lane = rd_addr[LANE_BITS-1:0];

  // Write port: full-word writes. Writes are dropped while reset is held.
  // The memory itself is never cleared, so this block can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read port: register the selected lane every cycle. The non-blocking read
  // of mem returns the pre-write contents on a same-word collision. Reset
  // clears only the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_word][rd_lane];
    end
  end

endmodule

// File: tb/tb_rd_frame_buf.sv
// tb_rd_frame_buf: directed self-checking bench for rd_frame_buf.
// Inputs change 1 ns after each rising edge. rd_data is sampled at the same
// point, so each check sees the read whose address was applied before the edge.
module tb_rd_frame_buf;

  localparam int WAW = 9;
  localparam int WDW = 256;
  localparam int RAW = 12;
  localparam int RDW = 32;

  logic           clk;
  logic           rst;
  logic           wr_en;
  logic [WAW-1:0] wr_addr;
  logic [WDW-1:0] wr_data;
  logic [RAW-1:0] rd_addr;
  logic [RDW-1:0] rd_data;

  int total;
  int passed;

  // Reference copy of the memory contents, maintained by the bench itself.
  logic [WDW-1:0] model [512];

  rd_frame_buf #(
    .WR_ADDR_WIDTH(WAW),
    .WR_DATA_WIDTH(WDW),
    .RD_ADDR_WIDTH(RAW),
    .RD_DATA_WIDTH(RDW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle 1 ns past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [RDW-1:0] obs, input logic [RDW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
  endtask

  // Fill pattern: lane k of word w = {w[8:0], k[2:0], 20'hA5A5A}.
  function automatic logic [RDW-1:0] pat(input logic [8:0] w, input logic [2:0] k);
    return {w, k, 20'hA5A5A};
  endfunction

  function automatic logic [RDW-1:0] lane_of(input logic [WDW-1:0] word, input logic [2:0] k);
    return word[k*32 +: 32];
  endfunction

  initial begin
    logic [WDW-1:0] d;
    logic [RDW-1:0] exp;
    logic [8:0]     wa;
    logic [RAW-1:0] ra;

    total   = 0;
    passed  = 0;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;

    // Reset held for 20 cycles with arbitrary read addresses.
    for (int i = 0; i < 20; i++) begin
      rd_addr = RAW'($urandom);
      tick();
      check("reset_rd_data", rd_data, 32'h0);
    end
    $display("reset: 20 cycles held, rd_data checked each cycle");
    rst = 1'b0;

    // Fill all 512 words with the lane pattern.
    wr_en = 1'b1;
    for (int w = 0; w < 512; w++) begin
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = pat(9'(w), 3'(k));
      wr_addr  = 9'(w);
      wr_data  = d;
      model[w] = d;
      tick();
    end
    wr_en = 1'b0;
    $display("fill: 512 words written");

    // Drain: sweep every read address once.
    for (int a = 0; a < 4096; a++) begin
      ra      = RAW'(a);
      rd_addr = ra;
      tick();
      check("sweep", rd_data, pat(ra[11:3], ra[2:0]));
    end
    $display("drain: 4096 lanes read");

    // Lane order: word 5 lane k = k, read addresses 40..47.
    for (int k = 0; k < 8; k++) d[k*32 +: 32] = 32'(k);
    wr_en    = 1'b1;
    wr_addr  = 9'd5;
    wr_data  = d;
    model[5] = d;
    tick();
    wr_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      rd_addr = RAW'(40 + k);
      tick();
      check("lane_order", rd_data, 32'(k));
      $display("lane_order: addr %0d -> %08h", 40 + k, rd_data);
    end

    // Read-first collision on word 3.
    wr_en    = 1'b1;
    wr_addr  = 9'd3;
    wr_data  = {WDW{1'b1}};
    model[3] = {WDW{1'b1}};
    tick();
    wr_data  = '0;
    model[3] = '0;
    rd_addr  = 12'd24;
    tick();
    check("collision_old", rd_data, 32'hFFFF_FFFF);
    $display("collision: same-cycle read addr 24 -> %08h", rd_data);
    wr_en = 1'b0;
    tick();
    check("collision_new", rd_data, 32'h0000_0000);
    $display("collision: next-cycle read addr 24 -> %08h", rd_data);

    // Write attempted during reset is lost.
    wr_en     = 1'b1;
    wr_addr   = 9'd10;
    wr_data   = {8{32'h1111_1111}};
    model[10] = {8{32'h1111_1111}};
    tick();
    rst     = 1'b1;
    wr_data = {8{32'h2222_2222}};
    rd_addr = 12'd80;
    tick();
    check("rst_mid_rd_data", rd_data, 32'h0);
    tick();
    check("rst_mid_hold", rd_data, 32'h0);
    rst   = 1'b0;
    wr_en = 1'b0;
    tick();
    check("rst_blocked_wr_lane0", rd_data, 32'h1111_1111);
    $display("reset_block: read addr 80 -> %08h", rd_data);
    rd_addr = 12'd87;
    tick();
    check("rst_blocked_wr_lane7", rd_data, 32'h1111_1111);
    $display("reset_block: read addr 87 -> %08h", rd_data);

    // Back-to-back random writes and reads against the model (read-first).
    for (int i = 0; i < 1000; i++) begin
      wa = 9'($urandom);
      ra = RAW'($urandom);
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      wr_en   = 1'b1;
      wr_addr = wa;
      wr_data = d;
      rd_addr = ra;
      exp     = lane_of(model[ra[11:3]], ra[2:0]);
      model[wa] = d;
      tick();
      check("random", rd_data, exp);
    end
    wr_en = 1'b0;
    $display("random: 1000 back-to-back cycles");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
